fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if_id_reg.sv | 58 +++++
 rtl/fetch_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage:
// FSM encoding, halt opcode and opcode field bounds.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam logic [4:0] HLT_OPC_DEF = 5'h1F;
   localparam int         OPC_HI      = 31;
   localparam int         OPC_LO      = 27;

   function automatic logic is_hlt(
      input logic [31:0] instr,
      input logic [4:0]  opc
   );
      return instr[OPC_HI:OPC_LO] == opc;
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction,
// clear the valid bit (flush/drain), or hold.
module if_id_reg #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [31:0]       in_instr,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [ADDR_W-1:0] in_pc_next,
   output logic              out_valid,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_next
);

   logic              valid_q, valid_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_next_q, pc_next_d;

   always_comb begin
      valid_d   = valid_q;
      instr_d   = instr_q;
      pc_d      = pc_q;
      pc_next_d = pc_next_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d   = 1'b1;
         instr_d   = in_instr;
         pc_d      = in_pc;
         pc_next_d = in_pc_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         instr_q   <= '0;
         pc_q      <= '0;
         pc_next_q <= '0;
      end else begin
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         pc_next_q <= pc_next_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_instr   = instr_q;
   assign out_pc      = pc_q;
   assign out_pc_next = pc_next_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: boot vector load, sequential fetch with
// backpressure, redirect flush and halt on HLT opcode.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = '0,
   parameter logic [4:0]      HLT_OPC   = HLT_OPC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_address,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_next,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic              load, clear, fire;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_inc = pc_q + ONE;
   assign fire   = !out_valid || out_ready;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      load         = 1'b0;
      clear        = 1'b0;
      imem_address = pc_q;
      // Redirect is ignored in BOOT, then outranks stall/fire/halt.
      if (state_q == ST_BOOT) begin
         imem_address = BOOT_ADDR;
         pc_d         = imem_data[ADDR_W-1:0];
         state_d      = ST_RUN;
      end else if (redirect_valid) begin
         pc_d    = redirect_pc;
         clear   = 1'b1;
         state_d = ST_RUN;
      end else if (state_q == ST_RUN && fire) begin
         load = 1'b1;
         pc_d = pc_inc;
         if (is_hlt(imem_data, HLT_OPC)) begin
            state_d = ST_HALTED;
         end
      end else if (out_valid && out_ready) begin
         clear = 1'b1;
      end
      halted_d = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_BOOT;
         pc_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;

   if_id_reg #(
      .ADDR_W(ADDR_W)
   ) u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .clear      (clear),
      .in_instr   (imem_data),
      .in_pc      (pc_q),
      .in_pc_next (pc_inc),
      .out_valid  (out_valid),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .out_pc_next(out_pc_next)
   );

endmodule
